el2_dccm_wr_buf: RTL and testbench

- Small in-order store buffer directly upstream of the DCCM write port of the core memory wrapper.
- Accepts ECC-encoded store words from the LSU commit stage and drives dccm_wren / dccm_wr_addr_lo/hi / dccm_wr_data_lo/hi.
- Drains one entry per cycle, only in cycles with no DCCM read.
- Provides youngest-match read-after-write forwarding, youngest-entry overwrite coalescing, and an empty indication for fences.

---
 rtl/el2_dccm_wr_buf.sv | 169 ++++++++++++++++
 tb/tb_el2_dccm_wr_buf.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/el2_dccm_wr_buf.sv
`default_nettype none
// ============================================================================
// Module   : el2_dccm_wr_buf
// Purpose  : In-order store buffer feeding the DCCM write port, with
//            youngest-match forwarding and youngest-entry coalescing.
// Revision : 1.0 - initial release
// ============================================================================
module el2_dccm_wr_buf #(
  parameter int DEPTH            = 4,
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_FDATA_WIDTH = 39
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        st_valid,
  output logic                        st_ready,
  input  logic [DCCM_BITS-1:0]        st_addr_lo,
  input  logic [DCCM_BITS-1:0]        st_addr_hi,
  input  logic [DCCM_FDATA_WIDTH-1:0] st_data_lo,
  input  logic [DCCM_FDATA_WIDTH-1:0] st_data_hi,
  input  logic                        dccm_rden,
  input  logic [DCCM_BITS-1:0]        fwd_addr,
  output logic                        fwd_hit,
  output logic [DCCM_FDATA_WIDTH-1:0] fwd_data,
  output logic                        dccm_wren,
  output logic [DCCM_BITS-1:0]        dccm_wr_addr_lo,
  output logic [DCCM_BITS-1:0]        dccm_wr_addr_hi,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_hi,
  output logic                        buf_empty,
  output logic                        buf_full
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_PW = c_AW + 1;

  logic [DCCM_BITS-1:0]        addr_lo_q [DEPTH];
  logic [DCCM_BITS-1:0]        addr_hi_q [DEPTH];
  logic [DCCM_FDATA_WIDTH-1:0] data_lo_q [DEPTH];
  logic [DCCM_FDATA_WIDTH-1:0] data_hi_q [DEPTH];

  logic [c_PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_PW-1:0] count_q, count_d;

  logic                        dccm_wren_q;
  logic [DCCM_BITS-1:0]        wr_addr_lo_q, wr_addr_hi_q;
  logic [DCCM_FDATA_WIDTH-1:0] wr_data_lo_q, wr_data_hi_q;

  logic            w_drain_fire;
  logic            w_accept;
  logic            w_coalesce;
  logic            w_push;
  logic            w_young_is_head;
  logic [c_PW-1:0] w_young_ptr;
  logic [c_AW-1:0] w_wr_idx, w_rd_idx, w_young_idx;
  logic            w_fwd_hit;
  logic [DCCM_FDATA_WIDTH-1:0] w_fwd_data;

  function automatic logic [c_PW-1:0] f_inc(input logic [c_PW-1:0] p);
    return (p == c_PW'(DEPTH - 1)) ? '0 : p + c_PW'(1);
  endfunction

  assign w_wr_idx        = wr_ptr_q[c_AW-1:0];
  assign w_rd_idx        = rd_ptr_q[c_AW-1:0];
  assign w_young_ptr     = (wr_ptr_q == '0) ? c_PW'(DEPTH - 1) : wr_ptr_q - c_PW'(1);
  assign w_young_idx     = w_young_ptr[c_AW-1:0];
  assign w_young_is_head = (w_young_ptr == rd_ptr_q);

  assign buf_full     = (count_q == c_PW'(DEPTH));
  assign buf_empty    = (count_q == '0) && !dccm_wren_q;
  assign w_drain_fire = (count_q != '0) && !dccm_rden;
  assign st_ready     = !buf_full || w_drain_fire;
  assign w_accept     = st_valid && st_ready;

  // Merge into the youngest entry only if it is not leaving this cycle
  assign w_coalesce = w_accept && (count_q != '0)
                   && (st_addr_lo == addr_lo_q[w_young_idx])
                   && (st_addr_hi == addr_hi_q[w_young_idx])
                   && !(w_drain_fire && w_young_is_head);
  assign w_push     = w_accept && !w_coalesce;

  always_comb begin
    wr_ptr_d = w_push ? f_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = w_drain_fire ? f_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (w_push && !w_drain_fire) begin
      count_d = count_q + c_PW'(1);
    end else if (!w_push && w_drain_fire) begin
      count_d = count_q - c_PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_coalesce) begin
      data_lo_q[w_young_idx] <= st_data_lo;
      data_hi_q[w_young_idx] <= st_data_hi;
    end else if (w_push) begin
      addr_lo_q[w_wr_idx] <= st_addr_lo;
      addr_hi_q[w_wr_idx] <= st_addr_hi;
      data_lo_q[w_wr_idx] <= st_data_lo;
      data_hi_q[w_wr_idx] <= st_data_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dccm_wren_q  <= 1'b0;
      wr_addr_lo_q <= '0;
      wr_addr_hi_q <= '0;
      wr_data_lo_q <= '0;
      wr_data_hi_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dccm_wren_q <= w_drain_fire;
      if (w_drain_fire) begin
        wr_addr_lo_q <= addr_lo_q[w_rd_idx];
        wr_addr_hi_q <= addr_hi_q[w_rd_idx];
        wr_data_lo_q <= data_lo_q[w_rd_idx];
        wr_data_hi_q <= data_hi_q[w_rd_idx];
      end
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest;
  // the in-flight write is older than anything still buffered.
  always_comb begin
    logic [c_AW-1:0] idx;
    idx        = '0;
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    if (dccm_wren_q) begin
      if (fwd_addr == wr_addr_lo_q) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = wr_data_lo_q;
      end else if (fwd_addr == wr_addr_hi_q) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = wr_data_hi_q;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = w_rd_idx + c_AW'(i);
      if (c_PW'(i) < count_q) begin
        if (fwd_addr == addr_lo_q[idx]) begin
          w_fwd_hit  = 1'b1;
          w_fwd_data = data_lo_q[idx];
        end else if (fwd_addr == addr_hi_q[idx]) begin
          w_fwd_hit  = 1'b1;
          w_fwd_data = data_hi_q[idx];
        end
      end
    end
  end

  assign fwd_hit         = w_fwd_hit;
  assign fwd_data        = w_fwd_data;
  assign dccm_wren       = dccm_wren_q;
  assign dccm_wr_addr_lo = wr_addr_lo_q;
  assign dccm_wr_addr_hi = wr_addr_hi_q;
  assign dccm_wr_data_lo = wr_data_lo_q;
  assign dccm_wr_data_hi = wr_data_hi_q;

endmodule
`default_nettype wire

// File: tb/tb_el2_dccm_wr_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_el2_dccm_wr_buf
// Purpose  : Self-checking bench for el2_dccm_wr_buf against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_el2_dccm_wr_buf;

  localparam int DEPTH = 4;
  localparam int AB    = 16;
  localparam int DW    = 39;

  logic          clk = 1'b0;
  logic          rst;
  logic          st_valid;
  logic          st_ready;
  logic [AB-1:0] st_addr_lo, st_addr_hi;
  logic [DW-1:0] st_data_lo, st_data_hi;
  logic          dccm_rden;
  logic [AB-1:0] fwd_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          dccm_wren;
  logic [AB-1:0] dccm_wr_addr_lo, dccm_wr_addr_hi;
  logic [DW-1:0] dccm_wr_data_lo, dccm_wr_data_hi;
  logic          buf_empty, buf_full;

  always #5 clk = ~clk;

  el2_dccm_wr_buf #(.DEPTH(DEPTH), .DCCM_BITS(AB), .DCCM_FDATA_WIDTH(DW)) u_dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr_lo(st_addr_lo), .st_addr_hi(st_addr_hi),
    .st_data_lo(st_data_lo), .st_data_hi(st_data_hi),
    .dccm_rden(dccm_rden), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .dccm_wren(dccm_wren), .dccm_wr_addr_lo(dccm_wr_addr_lo), .dccm_wr_addr_hi(dccm_wr_addr_hi),
    .dccm_wr_data_lo(dccm_wr_data_lo), .dccm_wr_data_hi(dccm_wr_data_hi),
    .buf_empty(buf_empty), .buf_full(buf_full)
  );

  typedef struct packed {
    logic [AB-1:0] alo;
    logic [AB-1:0] ahi;
    logic [DW-1:0] dlo;
    logic [DW-1:0] dhi;
  } ent_t;

  // Reference: pending stores as a plain queue plus the one write in flight
  ent_t mq[$];
  bit   m_fl_v = 1'b0;
  ent_t m_fl;
  bit   m_drain, m_accept, m_coal, m_rst;
  ent_t m_in;
  bit   e_ready, e_wren, e_empty, e_full, e_hit;
  logic [DW-1:0] e_fdata;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void fwd_match(input ent_t e);
    if (e.alo == fwd_addr) begin
      e_hit = 1'b1; e_fdata = e.dlo;
    end else if (e.ahi == fwd_addr) begin
      e_hit = 1'b1; e_fdata = e.dhi;
    end
  endfunction

  function automatic void model_eval();
    m_rst    = (rst === 1'b1);
    m_in     = {st_addr_lo, st_addr_hi, st_data_lo, st_data_hi};
    m_drain  = (mq.size() > 0) && !dccm_rden;
    e_ready  = (mq.size() < DEPTH) || m_drain;
    m_accept = st_valid && e_ready;
    m_coal   = m_accept && (mq.size() > 0) && (mq[$].alo == st_addr_lo)
            && (mq[$].ahi == st_addr_hi) && !(m_drain && mq.size() == 1);
    e_wren   = m_fl_v;
    e_empty  = (mq.size() == 0) && !m_fl_v;
    e_full   = (mq.size() == DEPTH);
    e_hit    = 1'b0;
    e_fdata  = '0;
    if (m_fl_v) fwd_match(m_fl);
    foreach (mq[i]) fwd_match(mq[i]);
  endfunction

  function automatic void model_commit();
    if (m_rst) begin
      mq.delete();
      m_fl_v = 1'b0;
      return;
    end
    m_fl_v = m_drain;
    if (m_drain) m_fl = mq.pop_front();
    if (m_coal) mq[$] = m_in;
    else if (m_accept) mq.push_back(m_in);
  endfunction

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic put(input logic v, input logic [AB-1:0] alo, input logic [AB-1:0] ahi,
                     input logic [DW-1:0] dlo, input logic [DW-1:0] dhi);
    st_valid = v; st_addr_lo = alo; st_addr_hi = ahi; st_data_lo = dlo; st_data_hi = dhi;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom(), $urandom()});
  endfunction

  task automatic drain_out(input string tag);
    st_valid  = 1'b0;
    dccm_rden = 1'b0;
    for (int k = 0; k < 3 * DEPTH + 4; k++) begin
      settle();
      if (e_empty) break;
      advance();
    end
    settle();
    n_checks++;
    if (buf_empty !== 1'b1) begin
      n_errors++; $display("FAIL %s_drain: buf_empty got %b exp 1", tag, buf_empty);
    end
    advance();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    settle(); advance();
    settle(); advance();
    rst = 1'b0;
    fwd_addr = 16'h0100;
    settle();
    n_checks++; if (dccm_wren !== 1'b0) begin n_errors++; $display("FAIL rst_wren: got %b exp 0", dccm_wren); end
    n_checks++; if (buf_empty !== 1'b1) begin n_errors++; $display("FAIL rst_empty: got %b exp 1", buf_empty); end
    n_checks++; if (buf_full !== 1'b0) begin n_errors++; $display("FAIL rst_full: got %b exp 0", buf_full); end
    n_checks++; if (st_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready: got %b exp 1", st_ready); end
    n_checks++; if (fwd_hit !== 1'b0) begin n_errors++; $display("FAIL rst_fwd_hit: got %b exp 0", fwd_hit); end
    advance();
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    d = 39'h12_3456_789A;
    dccm_rden = 1'b0;
    put(1'b1, 16'h0100, 16'h0100, d, d);
    settle();
    n_checks++; if (st_ready !== 1'b1) begin n_errors++; $display("FAIL single_ready: got %b exp 1", st_ready); end
    advance();
    st_valid = 1'b0;
    settle();
    n_checks++; if (dccm_wren !== 1'b0) begin n_errors++; $display("FAIL single_lat1: wren got %b exp 0", dccm_wren); end
    advance();
    settle();
    n_checks++; if (dccm_wren !== 1'b1) begin n_errors++; $display("FAIL single_lat2: wren got %b exp 1", dccm_wren); end
    n_checks++; if (dccm_wr_addr_lo !== 16'h0100) begin n_errors++; $display("FAIL single_addr: got %h exp 0100", dccm_wr_addr_lo); end
    n_checks++; if (dccm_wr_data_lo !== d) begin n_errors++; $display("FAIL single_data: got %h exp %h", dccm_wr_data_lo, d); end
    n_checks++; if (buf_empty !== 1'b0) begin n_errors++; $display("FAIL single_busy: buf_empty got %b exp 0", buf_empty); end
    advance();
    settle();
    n_checks++; if (buf_empty !== 1'b1) begin n_errors++; $display("FAIL single_empty: got %b exp 1", buf_empty); end
    n_checks++; if (dccm_wren !== 1'b0) begin n_errors++; $display("FAIL single_once: wren got %b exp 0", dccm_wren); end
    advance();
  endtask

  task automatic test_full();
    logic [AB-1:0] ea [5];
    for (int i = 0; i < 4; i++) ea[i] = AB'(16'h0400 + 4 * i);
    ea[4] = 16'h0500;
    dccm_rden = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put(1'b1, ea[i], ea[i], DW'(32'hD000_0000) + DW'(ea[i]), '0);
      settle(); advance();
    end
    put(1'b1, ea[4], ea[4], DW'(32'hD000_0000) + DW'(ea[4]), '0);
    settle();
    n_checks++; if (buf_full !== 1'b1) begin n_errors++; $display("FAIL full_flag: got %b exp 1", buf_full); end
    n_checks++; if (st_ready !== 1'b0) begin n_errors++; $display("FAIL full_ready: got %b exp 0", st_ready); end
    advance();
    dccm_rden = 1'b0;
    settle();
    n_checks++; if (st_ready !== 1'b1) begin n_errors++; $display("FAIL full_pushpop: st_ready got %b exp 1", st_ready); end
    advance();
    st_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      settle();
      n_checks++;
      if (dccm_wren !== (k < 5)) begin
        n_errors++; $display("FAIL full_order_wren[%0d]: got %b exp %b", k, dccm_wren, (k < 5));
      end else if (k < 5 && (dccm_wr_addr_lo !== ea[k] || dccm_wr_data_lo !== DW'(32'hD000_0000) + DW'(ea[k]))) begin
        n_errors++; $display("FAIL full_order[%0d]: got %h/%h exp %h", k, dccm_wr_addr_lo, dccm_wr_data_lo, ea[k]);
      end
      advance();
    end
  endtask

  task automatic test_coalesce();
    logic [DW-1:0] da, db;
    int nw;
    da = 39'h11_1111_1111;
    db = 39'h22_2222_2222;
    nw = 0;
    dccm_rden = 1'b1;
    put(1'b1, 16'h0200, 16'h0200, da, da);
    settle(); advance();
    put(1'b1, 16'h0200, 16'h0200, db, db);
    settle(); advance();
    st_valid = 1'b0;
    fwd_addr = 16'h0200;
    settle();
    n_checks++; if (fwd_hit !== 1'b1 || fwd_data !== db) begin n_errors++; $display("FAIL coal_fwd: got %b/%h exp 1/%h", fwd_hit, fwd_data, db); end
    dccm_rden = 1'b0;
    for (int k = 0; k < 5; k++) begin
      settle();
      if (dccm_wren === 1'b1) begin
        nw++;
        n_checks++; if (dccm_wr_data_lo !== db) begin n_errors++; $display("FAIL coal_data: got %h exp %h", dccm_wr_data_lo, db); end
      end
      advance();
    end
    n_checks++; if (nw !== 1) begin n_errors++; $display("FAIL coal_count: writes got %0d exp 1", nw); end
  endtask

  task automatic test_forward();
    logic [DW-1:0] dx, dy, dz;
    dx = rnd_data(); dy = rnd_data(); dz = rnd_data();
    dccm_rden = 1'b1;
    put(1'b1, 16'h0300, 16'h0300, dx, dx); settle(); advance();
    put(1'b1, 16'h0304, 16'h0304, dy, dy); settle(); advance();
    put(1'b1, 16'h0300, 16'h0300, dz, dz); settle(); advance();
    st_valid = 1'b0;
    fwd_addr = 16'h0300;
    settle();
    n_checks++; if (fwd_hit !== 1'b1 || fwd_data !== dz) begin n_errors++; $display("FAIL fwd_young: got %b/%h exp 1/%h", fwd_hit, fwd_data, dz); end
    fwd_addr = 16'h0304;
    settle();
    n_checks++; if (fwd_hit !== 1'b1 || fwd_data !== dy) begin n_errors++; $display("FAIL fwd_mid: got %b/%h exp 1/%h", fwd_hit, fwd_data, dy); end
    fwd_addr = 16'h0308;
    settle();
    n_checks++; if (fwd_hit !== 1'b0) begin n_errors++; $display("FAIL fwd_miss: got %b exp 0", fwd_hit); end
    advance();
    drain_out("fwd");
  endtask

  task automatic test_wrap();
    ent_t exp_q[$];
    ent_t e;
    int pushed, got;
    bit done;
    pushed = 0; got = 0; done = 1'b0;
    for (int c = 0; c < 120 && !done; c++) begin
      dccm_rden = (c % 2 == 1);
      if (pushed < 10) put(1'b1, AB'(16'h0600 + 4 * pushed), AB'(16'h0600 + 4 * pushed), rnd_data(), rnd_data());
      else st_valid = 1'b0;
      settle();
      if (m_accept) begin exp_q.push_back(m_in); pushed++; end
      if (dccm_wren === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++; $display("FAIL wrap_extra: unexpected write addr %h", dccm_wr_addr_lo);
        end else begin
          e = exp_q.pop_front();
          got++;
          if ({dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_wr_data_lo, dccm_wr_data_hi} !== e) begin
            n_errors++; $display("FAIL wrap_order[%0d]: got %h/%h exp %h/%h", got - 1, dccm_wr_addr_lo, dccm_wr_data_lo, e.alo, e.dlo);
          end
        end
      end
      if (pushed == 10 && e_empty) done = 1'b1;
      advance();
    end
    n_checks++; if (got !== 10) begin n_errors++; $display("FAIL wrap_count: writes got %0d exp 10", got); end
  endtask

  task automatic test_reset_mid();
    dccm_rden = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put(1'b1, AB'(16'h0700 + 4 * i), AB'(16'h0700 + 4 * i), rnd_data(), rnd_data());
      settle(); advance();
    end
    st_valid  = 1'b0;
    dccm_rden = 1'b0;
    settle(); advance();
    settle();
    n_checks++; if (dccm_wren !== 1'b1) begin n_errors++; $display("FAIL rstmid_inflight: wren got %b exp 1", dccm_wren); end
    rst = 1'b1;
    settle(); advance();
    rst = 1'b0;
    settle();
    n_checks++; if (dccm_wren !== 1'b0) begin n_errors++; $display("FAIL rstmid_wren: got %b exp 0", dccm_wren); end
    n_checks++; if (buf_empty !== 1'b1) begin n_errors++; $display("FAIL rstmid_empty: got %b exp 1", buf_empty); end
    n_checks++; if (st_ready !== 1'b1) begin n_errors++; $display("FAIL rstmid_ready: got %b exp 1", st_ready); end
    advance();
    for (int k = 0; k < 6; k++) begin
      settle();
      n_checks++; if (dccm_wren !== 1'b0) begin n_errors++; $display("FAIL rstmid_quiet[%0d]: wren got %b exp 0", k, dccm_wren); end
      advance();
    end
  endtask

  task automatic test_random();
    logic [AB-1:0] a;
    for (int c = 0; c < 400; c++) begin
      a = AB'(16'h0800 + 4 * $urandom_range(0, 5));
      put($urandom_range(0, 9) < 6, a, ($urandom_range(0, 1) == 1) ? a : a + AB'(4), rnd_data(), rnd_data());
      dccm_rden = ($urandom_range(0, 9) < 4);
      fwd_addr  = AB'(16'h0800 + 4 * $urandom_range(0, 7));
      settle();
      n_checks++; if (st_ready !== e_ready) begin n_errors++; $display("FAIL rnd_ready@%0d: got %b exp %b", c, st_ready, e_ready); end
      n_checks++; if (buf_full !== e_full) begin n_errors++; $display("FAIL rnd_full@%0d: got %b exp %b", c, buf_full, e_full); end
      n_checks++; if (buf_empty !== e_empty) begin n_errors++; $display("FAIL rnd_empty@%0d: got %b exp %b", c, buf_empty, e_empty); end
      n_checks++; if (dccm_wren !== e_wren) begin n_errors++; $display("FAIL rnd_wren@%0d: got %b exp %b", c, dccm_wren, e_wren); end
      if (e_wren) begin
        n_checks++;
        if ({dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_wr_data_lo, dccm_wr_data_hi} !== m_fl) begin
          n_errors++; $display("FAIL rnd_wdata@%0d: got %h/%h exp %h/%h", c, dccm_wr_addr_lo, dccm_wr_data_lo, m_fl.alo, m_fl.dlo);
        end
      end
      n_checks++; if (fwd_hit !== e_hit) begin n_errors++; $display("FAIL rnd_fwd_hit@%0d: got %b exp %b", c, fwd_hit, e_hit); end
      if (e_hit) begin
        n_checks++; if (fwd_data !== e_fdata) begin n_errors++; $display("FAIL rnd_fwd_data@%0d: got %h exp %h", c, fwd_data, e_fdata); end
      end
      advance();
    end
    drain_out("rnd");
  endtask

  initial begin
    rst = 1'b1; dccm_rden = 1'b0; fwd_addr = '0;
    put(1'b0, '0, '0, '0, '0);
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_full();
    test_coalesce();
    test_forward();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
